// File: rtl/pacote_ula.sv
// pacote_ula: shared codes for the multi-cycle ALU control block.
//   ula_opcode codes, funcao codes, ula_control codes and FSM states.
package pacote_ula;
  typedef enum logic [1:0] {
    OP_TIPO_R = 2'b00,
    OP_ADDI   = 2'b01,
    OP_SLTI   = 2'b10,
    OP_BEQ    = 2'b11
  } ula_opcode_t;
  localparam int F_ADD   = 0;
  localparam int F_SUB   = 1;
  localparam int F_AND   = 2;
  localparam int F_OR    = 3;
  localparam int F_MENOR = 4;
  localparam int F_XOR   = 5;
  localparam int F_SLL   = 6;
  localparam int F_SRL   = 7;
  localparam int F_JR    = 8;
  localparam int F_MULTU = 9;
  localparam int F_DIVU  = 10;
  localparam int F_MFHI  = 11;
  localparam int F_MFLO  = 12;
  localparam logic [3:0] C_ADD   = 4'b0000;
  localparam logic [3:0] C_SUB   = 4'b0001;
  localparam logic [3:0] C_AND   = 4'b0010;
  localparam logic [3:0] C_OR    = 4'b0011;
  localparam logic [3:0] C_MENOR = 4'b0100;
  localparam logic [3:0] C_XOR   = 4'b0101;
  localparam logic [3:0] C_SLL   = 4'b0110;
  localparam logic [3:0] C_SRL   = 4'b0111;
  localparam logic [3:0] C_MFHI  = 4'b1000;
  localparam logic [3:0] C_MFLO  = 4'b1001;
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_t;
endpackage

// File: rtl/multdiv_iterativo.sv
// multdiv_iterativo: iterative unsigned multiply/divide datapath with HI/LO.
//   clock, reset_n : clock and synchronous active-low reset
//   carrega        : accept edge; latches operands/operation, loads counter
//   passo          : perform one iteration step
//   divide         : operation to latch on carrega (1 = DIVU, 0 = MULTU)
//   operando_a/b   : multiplicand/dividend and multiplier/divisor
//   ultimo         : current step is the last one (counter == 1)
//   hi, lo         : result registers
module multdiv_iterativo
  import pacote_ula::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               carrega,
  input  logic               passo,
  input  logic               divide,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  output logic               ultimo,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo
);
  localparam int CW = $clog2(LARGURA + 1);
  logic [LARGURA-1:0] acc, q, m, acc_prox, q_prox;
  logic [LARGURA:0]   soma, desloc, dif;
  logic               div_op;
  logic [CW-1:0]      contador;
  // {acc,q} is the product being shifted right (MULTU) or the
  // remainder/quotient pair being shifted left (DIVU); dif[MSB] set means
  // the trial subtraction went negative, so the remainder is restored.
  always_comb begin
    soma     = {1'b0, acc} + {1'b0, q[0] ? m : '0};
    desloc   = {acc, q[LARGURA-1]};
    dif      = desloc - {1'b0, m};
    acc_prox = div_op ? (dif[LARGURA] ? desloc[LARGURA-1:0] : dif[LARGURA-1:0]) : soma[LARGURA:1];
    q_prox   = div_op ? {q[LARGURA-2:0], ~dif[LARGURA]} : {soma[0], q[LARGURA-1:1]};
    ultimo   = contador == CW'(1);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      div_op   <= 1'b0;
      contador <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (carrega) begin
      acc      <= '0;
      q        <= operando_a;
      m        <= operando_b;
      div_op   <= divide;
      contador <= CW'(LARGURA);
      if (divide && operando_b == '0) begin
        hi <= operando_a;
        lo <= '1;
      end
    end else if (passo) begin
      acc      <= acc_prox;
      q        <= q_prox;
      contador <= contador - CW'(1);
      if (ultimo) begin
        hi <= acc_prox;
        lo <= q_prox;
      end
    end
  end
endmodule

// File: rtl/controle_ula_multiciclo.sv
// controle_ula_multiciclo: ALU control decode plus multi-cycle MULTU/DIVU engine.
//   clock, reset_n         : clock and synchronous active-low reset
//   ula_opcode, funcao     : instruction class and R-type function code
//   inicio                 : start request for MULTU/DIVU
//   operando_a, operando_b : engine operands
//   ula_control, controle_jr : combinational decode outputs
//   ocupado, pronto, parada  : busy, one-cycle done pulse, pipeline stall
//   hi, lo                 : product halves or remainder/quotient
module controle_ula_multiciclo
  import pacote_ula::*;
#(
  parameter int LARGURA        = 32,
  parameter int LARGURA_FUNCAO = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0]                ula_opcode,
  input  logic [LARGURA_FUNCAO-1:0] funcao,
  input  logic                      inicio,
  input  logic [LARGURA-1:0]        operando_a,
  input  logic [LARGURA-1:0]        operando_b,
  output logic [3:0]                ula_control,
  output logic                      controle_jr,
  output logic                      ocupado,
  output logic                      pronto,
  output logic                      parada,
  output logic [LARGURA-1:0]        hi,
  output logic [LARGURA-1:0]        lo
);
  localparam int LF = LARGURA_FUNCAO;
  estado_t    estado, prox;
  logic [3:0] ctrl_r;
  logic       tipo_r, eh_multu, eh_divu, eh_hilo, aceita, div_zero, ultimo;
  always_comb begin
    ctrl_r = C_ADD;
    case (funcao)
      LF'(F_SUB):   ctrl_r = C_SUB;
      LF'(F_AND):   ctrl_r = C_AND;
      LF'(F_OR):    ctrl_r = C_OR;
      LF'(F_MENOR): ctrl_r = C_MENOR;
      LF'(F_XOR):   ctrl_r = C_XOR;
      LF'(F_SLL):   ctrl_r = C_SLL;
      LF'(F_SRL):   ctrl_r = C_SRL;
      LF'(F_MFHI):  ctrl_r = C_MFHI;
      LF'(F_MFLO):  ctrl_r = C_MFLO;
      default:      ctrl_r = C_ADD;
    endcase
    tipo_r      = ula_opcode == OP_TIPO_R;
    ula_control = tipo_r ? ctrl_r : ula_opcode == OP_ADDI ? C_ADD : ula_opcode == OP_SLTI ? C_MENOR : C_SUB;
    controle_jr = tipo_r && funcao == LF'(F_JR);
    eh_multu    = tipo_r && funcao == LF'(F_MULTU);
    eh_divu     = tipo_r && funcao == LF'(F_DIVU);
    eh_hilo     = eh_multu || eh_divu || (tipo_r && (funcao == LF'(F_MFHI) || funcao == LF'(F_MFLO)));
    aceita      = reset_n && estado == OCIOSO && inicio && (eh_multu || eh_divu);
    div_zero    = eh_divu && operando_b == '0;
    prox        = estado == OCIOSO ? (aceita ? (div_zero ? FIM : CALCULA) : OCIOSO)
                : estado == CALCULA ? (ultimo ? FIM : CALCULA) : OCIOSO;
    // The issuing instruction itself stalls on its accept cycle.
    parada      = (ocupado && eh_hilo) || aceita;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado  <= OCIOSO;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      estado  <= prox;
      ocupado <= prox != OCIOSO;
      pronto  <= prox == FIM;
    end
  end
  multdiv_iterativo #(.LARGURA(LARGURA)) u_multdiv (
    .clock      (clock),
    .reset_n    (reset_n),
    .carrega    (aceita),
    .passo      (estado == CALCULA),
    .divide     (eh_divu),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .ultimo     (ultimo),
    .hi         (hi),
    .lo         (lo)
  );
endmodule

// File: tb/tb_controle_ula_multiciclo.sv
// tb_controle_ula_multiciclo: self-checking bench for controle_ula_multiciclo.
module tb_controle_ula_multiciclo;
  localparam int W = 32;
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   ula_opcode = 2'b00;
  logic [3:0]   funcao = 4'd0;
  logic         inicio = 1'b0;
  logic [W-1:0] operando_a = '0, operando_b = '0;
  logic [3:0]   ula_control;
  logic         controle_jr, ocupado, pronto, parada;
  logic [W-1:0] hi, lo;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] f;
    logic [3:0] ctrl;
    logic       jr;
  } vec_t;
  vec_t vet[64];

  controle_ula_multiciclo #(.LARGURA(W), .LARGURA_FUNCAO(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ula_opcode  (ula_opcode),
    .funcao      (funcao),
    .inicio      (inicio),
    .operando_a  (operando_a),
    .operando_b  (operando_b),
    .ula_control (ula_control),
    .controle_jr (controle_jr),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .parada      (parada),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [3:0] f);
    if (op == 2'd1) return 4'd0;
    if (op == 2'd2) return 4'd4;
    if (op == 2'd3) return 4'd1;
    if (f <= 4'd7) return f;
    if (f == 4'd11) return 4'd8;
    if (f == 4'd12) return 4'd9;
    return 4'd0;
  endfunction

  task automatic espera_pronto(output int n);
    n = 0;
    while (!pronto && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) chk("pronto_timeout", 64'(n), 64'(W));
  endtask

  task automatic executa(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string nome);
    logic [63:0]  p;
    logic [W-1:0] eh, el;
    int           lat, n;
    if (f == 4'd9) begin
      p  = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a;
      el = '1;
    end else begin
      eh = a % b;
      el = a / b;
    end
    lat = (f == 4'd10 && b == 0) ? 0 : W;
    ula_opcode = 2'b00;
    funcao = f;
    operando_a = a;
    operando_b = b;
    inicio = 1'b1;
    #1;
    chk({nome, "_parada_emissao"}, 64'(parada), 64'd1);
    tick;
    inicio = 1'b0;
    funcao = 4'd0;
    #1;
    chk({nome, "_parada_add_ocupado"}, 64'(parada), 64'd0);
    espera_pronto(n);
    chk({nome, "_latencia"}, 64'(n), 64'(lat));
    chk({nome, "_hi"}, 64'(hi), 64'(eh));
    chk({nome, "_lo"}, 64'(lo), 64'(el));
    tick;
    chk({nome, "_pulso"}, 64'({pronto, ocupado}), 64'd0);
    chk({nome, "_hi_mantem"}, 64'(hi), 64'(eh));
  endtask

  initial begin
    int n, e0, intervalo;
    for (int o = 0; o < 4; o++)
      for (int f = 0; f < 16; f++) begin
        vet[o*16+f].op   = 2'(o);
        vet[o*16+f].f    = 4'(f);
        vet[o*16+f].ctrl = ref_ctrl(2'(o), 4'(f));
        vet[o*16+f].jr   = (o == 0 && f == 8);
      end

    repeat (3) tick;
    chk("reset_ocupado", 64'(ocupado), 64'd0);
    chk("reset_pronto", 64'(pronto), 64'd0);
    chk("reset_parada", 64'(parada), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 64; i++) begin
      ula_opcode = vet[i].op;
      funcao = vet[i].f;
      #1;
      chk($sformatf("decode_ctrl_op%0d_f%0d", vet[i].op, vet[i].f), 64'(ula_control), 64'(vet[i].ctrl));
      chk($sformatf("decode_jr_op%0d_f%0d", vet[i].op, vet[i].f), 64'(controle_jr), 64'(vet[i].jr));
    end
    ula_opcode = 2'b00;
    funcao = 4'd0;

    executa(4'd9, 32'd7, 32'd6, "multu_7x6");
    executa(4'd9, 32'hFFFFFFFF, 32'd2, "multu_max_x2");
    executa(4'd10, 32'd100, 32'd7, "divu_100_7");
    executa(4'd10, 32'd5, 32'd0, "divu_5_0");

    funcao = 4'd9;
    operando_a = 32'd7;
    operando_b = 32'd6;
    inicio = 1'b1;
    tick;
    funcao = 4'd10;
    operando_a = 32'd100;
    operando_b = 32'd7;
    repeat (3) tick;
    chk("ocupado_durante", 64'(ocupado), 64'd1);
    chk("parada_divu_ocupado", 64'(parada), 64'd1);
    funcao = 4'd12;
    inicio = 1'b0;
    #1;
    chk("parada_mflo_ocupado", 64'(parada), 64'd1);
    funcao = 4'd0;
    #1;
    chk("parada_add_ocupado", 64'(parada), 64'd0);
    espera_pronto(n);
    chk("ignora_hi", 64'(hi), 64'd0);
    chk("ignora_lo", 64'(lo), 64'd42);
    tick;

    funcao = 4'd9;
    operando_a = 32'hFFFF;
    operando_b = 32'hFFFF;
    inicio = 1'b1;
    tick;
    inicio = 1'b0;
    funcao = 4'd0;
    repeat (10) tick;
    reset_n = 1'b0;
    tick;
    chk("reset_meio_ocupado", 64'(ocupado), 64'd0);
    chk("reset_meio_pronto", 64'(pronto), 64'd0);
    chk("reset_meio_parada", 64'(parada), 64'd0);
    chk("reset_meio_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    repeat (W + 2) tick;
    chk("reset_descarta", 64'({pronto, ocupado}), 64'd0);
    executa(4'd9, 32'd3, 32'd3, "multu_3x3_pos_reset");

    funcao = 4'd9;
    operando_a = 32'd5;
    operando_b = 32'd6;
    inicio = 1'b1;
    tick;
    e0 = 0;
    espera_pronto(n);
    chk("b2b_primeiro_lo", 64'(lo), 64'd30);
    operando_a = 32'd7;
    operando_b = 32'd8;
    intervalo = n;
    while (ocupado && intervalo < 200) begin tick; intervalo++; end
    while (!ocupado && intervalo < 200) begin tick; intervalo++; end
    chk("b2b_intervalo", 64'(intervalo - e0), 64'(W + 2));
    inicio = 1'b0;
    espera_pronto(n);
    chk("b2b_segundo_lo", 64'(lo), 64'd56);
    chk("b2b_segundo_hi", 64'(hi), 64'd0);
    tick;

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (i % 8 == 2) ? 32'd0 : $urandom_range(1, 15);
        default: b = $urandom_range(0, 65535);
      endcase
      executa($urandom_range(0, 1) ? 4'd9 : 4'd10, a, b, $sformatf("aleatorio_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_ula_multiciclo.md
Name: controle_ula_multiciclo

Overview:
Parametrised successor of the ALU control decoder.
- Decodes ula_opcode/funcao into a 4-bit ALU control code and flags jr.
- Adds an iterative multi-cycle unsigned multiply/divide engine with HI/LO registers, plus a start/busy/done handshake and a pipeline stall output.
- Sits in the execute stage beside the ALU; the hazard logic consumes `parada`.

Parameters:
LARGURA, 32, operand, HI and LO width in bits (≥4).
LARGURA_FUNCAO, 4, funcao field width (≥4); codes are zero-extended to this width.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
ula_opcode  in  2  00 TIPO_R, 01 ADDI, 10 SLTI, 11 BEQ
funcao  in  LARGURA_FUNCAO  R-type function code
inicio  in  1  request to start MULTU/DIVU; qualified by decode
operando_a  in  LARGURA  multiplicand / dividend
operando_b  in  LARGURA  multiplier / divisor
ula_control  out  4  ALU operation code (combinational)
controle_jr  out  1  instruction is jr (combinational)
ocupado  out  1  engine is computing
pronto  out  1  one-cycle pulse; result is valid
parada  out  1  stall request to the pipeline
hi  out  LARGURA  product upper half / remainder
lo  out  LARGURA  product lower half / quotient

Behaviour:
- Decode (combinational):
  - TIPO_R funcao mapping to ula_control: ADD 0→0000, SUB 1→0001, AND 2→0010, OR 3→0011, MENOR 4→0100, XOR 5→0101, SLL 6→0110, SRL 7→0111, MFHI 11→1000, MFLO 12→1001. All other funcao values, including MULTU, DIVU and JR, give 0000.
  - ADDI→0000, SLTI→0100, BEQ→0001.
  - controle_jr=1 only when ula_opcode=00 and funcao=8.
- Start condition: an operation is accepted on a rising edge when reset_n=1, state=OCIOSO, inicio=1, ula_opcode=00, and funcao=9 (MULTU) or funcao=10 (DIVU). inicio is ignored otherwise, including while busy.
- Accept edge: latches the operands and the operation, loads counter=LARGURA, and clears the working accumulator.
- FSM states:
  - OCIOSO → CALCULA on accept.
  - CALCULA: performs one shift-add (MULTU) or one restoring shift-subtract (DIVU) step per cycle; counter decrements each step. Transition to FIM on the edge where counter goes 1→0, i.e. exactly LARGURA cycles in CALCULA.
  - FIM → OCIOSO after one cycle.
- DIVU with operando_b=0: goes OCIOSO → FIM directly with hi=operando_a and lo=all ones (latency 1 instead of LARGURA+1).
- Latency: with the accept edge at t0, pronto=1 for exactly the cycle after edge t0+LARGURA. hi/lo are updated on that same edge and hold until the next completion or reset.
- Outputs by state:
  - ocupado=1 in CALCULA and FIM.
  - pronto=1 only in FIM.
- parada=1 when either:
  - ocupado=1 and the current instruction is MULTU, DIVU, MFHI or MFLO; or
  - state=OCIOSO and a start condition is true in that cycle (the issuing instruction stalls one cycle).
  
  Otherwise parada=0.
- Width rules:
  - MULTU computes a 2·LARGURA-bit unsigned product: hi=upper half, lo=lower half.
  - DIVU: lo=quotient, hi=remainder, both unsigned.
  - No overflow flag.
- Reset (reset_n=0 at a rising edge, any state, including mid-operation): state=OCIOSO, counter=0, hi=0, lo=0, ocupado=0, pronto=0, parada=0. The interrupted operation is discarded.
- Back-to-back: a new start condition is accepted during the FIM cycle only after returning to OCIOSO, so the minimum issue interval is LARGURA+2 cycles.

Decomposition:
- Package pacote_ula holds:
  - ula_opcode codes;
  - funcao codes ADD..SRL, JR=8, MULTU=9, DIVU=10, MFHI=11, MFLO=12;
  - ula_control codes;
  - FSM state encoding OCIOSO/CALCULA/FIM.
- One sub-module, multdiv_iterativo, contains the operand/accumulator registers, the counter and the step datapath. The top level keeps the decode, FSM and stall logic.

Test Plan:
- Decode sweep: every ula_opcode × funcao 0..15 → ula_control/controle_jr match the table; only {00,8} gives jr=1.
- MULTU, LARGURA=32: operands 7 × 6 → pronto exactly 33 cycles after the accept edge, hi=0, lo=42. Operands 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- DIVU 100 / 7 → lo=14, hi=2 after LARGURA+1 cycles. DIVU 5 / 0 → pronto on the cycle after accept, hi=5, lo=0xFFFFFFFF.
- inicio repeated while ocupado=1 with new operands → ignored; hi/lo equal the first operation's result; parada=1 for an MFLO issued while busy.
- reset_n=0 mid-CALCULA (cycle 10) → next cycle all outputs 0, state OCIOSO; a fresh MULTU 3 × 3 afterwards yields lo=9.
- Two MULTU operations issued back-to-back → the second is accepted only after FIM; the interval is ≥ LARGURA+2 cycles and both results are correct.
